// File: rtl/mem_stage_if.sv
// Handshake and data bundle between mem_stage and its neighbours (EXE, WB, decode, dcache).
// master = the environment side, slave = mem_stage itself.
interface mem_stage_if #(
    parameter int WD = 215
);
    logic          ws_allowin;
    logic          ms_allowin;
    logic          es_to_ms_valid;
    logic [WD-1:0] es_to_ms_bus;
    logic          ms_to_ws_valid;
    logic [WD-1:0] ms_to_ws_bus;
    logic [38:0]   ms_to_ds_forward_bus;
    logic          data_data_ok;
    logic [31:0]   data_rdata;
    logic          excp_flush;
    logic          ertn_flush;
    logic          refetch_flush;
    logic          icacop_flush;
    logic          ms_flush;
    logic          ms_wr_tlbehi;

    modport master (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_data_ok, data_rdata,
               excp_flush, ertn_flush, refetch_flush, icacop_flush,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_forward_bus,
               ms_flush, ms_wr_tlbehi
    );

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_data_ok, data_rdata,
               excp_flush, ertn_flush, refetch_flush, icacop_flush,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_forward_bus,
               ms_flush, ms_wr_tlbehi
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for dcache responses, aligns load data, forwards to decode.
// Define MS_FWD_EN to enable result forwarding; otherwise decode stalls on any MEM dependency.
module mem_stage #(
    parameter int          ES_TO_MS_BUS_WD = 215,
    parameter logic [13:0] CSR_TLBEHI      = 14'h11
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  ms
);
    localparam int WD = ES_TO_MS_BUS_WD;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        state_q;
    logic          ms_valid_q;
    logic [WD-1:0] bus_q;
    logic          req_q;
    logic [31:0]   rbuf_q;
    logic [1:0]    cancel_cnt_q;

    logic [31:0] exe_result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        load_op;
    logic [1:0]  mem_size;
    logic        excp;
    logic        ertn;
    logic [13:0] csr_idx;
    logic        csr_we;
    logic        tlbsrch;
    logic        refetch;
    logic        mem_sign_exted;

    assign exe_result     = bus_q[63:32];
    assign dest           = bus_q[68:64];
    assign gr_we          = bus_q[69];
    assign load_op        = bus_q[70];
    assign mem_size       = bus_q[76:75];
    assign excp           = bus_q[77];
    assign ertn           = bus_q[78];
    assign csr_idx        = bus_q[124:111];
    assign csr_we         = bus_q[125];
    assign tlbsrch        = bus_q[172];
    assign refetch        = bus_q[175];
    assign mem_sign_exted = bus_q[207];

    logic in_req;
    logic flush_any;
    logic in_wait;
    logic in_hold;
    logic ms_ready_go;
    logic entry;
    logic req_entry;

    // A request is outstanding at the dcache only for real loads/stores that EXE actually issued.
    assign in_req = (ms.es_to_ms_bus[70] | ms.es_to_ms_bus[171]) & ~ms.es_to_ms_bus[77]
                  & ~ms.es_to_ms_bus[214] & ~ms.es_to_ms_bus[213];

    assign flush_any   = ms.excp_flush | ms.ertn_flush | ms.refetch_flush | ms.icacop_flush;
    assign in_wait     = (state_q == S_WAIT);
    assign in_hold     = (state_q == S_HOLD);
    assign ms_ready_go = ~req_q | (in_wait & ms.data_data_ok) | in_hold;
    assign ms.ms_allowin = (cancel_cnt_q == 2'd0) & (~ms_valid_q | (ms_ready_go & ms.ws_allowin));
    assign entry       = ms.es_to_ms_valid & ms.ms_allowin & ~flush_any;
    assign req_entry   = entry & in_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ms_valid_q   <= 1'b0;
            bus_q        <= '0;
            req_q        <= 1'b0;
            rbuf_q       <= 32'd0;
            cancel_cnt_q <= 2'd0;
        end else begin
            if (flush_any) begin
                ms_valid_q <= 1'b0;
            end else if (ms.ms_allowin) begin
                ms_valid_q <= ms.es_to_ms_valid;
            end

            if (entry) begin
                bus_q <= ms.es_to_ms_bus;
                req_q <= in_req;
            end

            // Responses still owed to flushed requests must be swallowed before new entries.
            if (flush_any && in_wait && !ms.data_data_ok) begin
                if (cancel_cnt_q != 2'd3) begin
                    cancel_cnt_q <= cancel_cnt_q + 2'd1;
                end
            end else if (ms.data_data_ok && !in_wait && cancel_cnt_q != 2'd0) begin
                cancel_cnt_q <= cancel_cnt_q - 2'd1;
            end

            if (flush_any) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (req_entry) begin
                            state_q <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (ms.data_data_ok) begin
                            if (ms.ws_allowin) begin
                                state_q <= req_entry ? S_WAIT : S_IDLE;
                            end else begin
                                state_q <= S_HOLD;
                                rbuf_q  <= ms.data_rdata;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (ms.ws_allowin) begin
                            state_q <= req_entry ? S_WAIT : S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    logic [31:0] load_sel;
    logic [31:0] load_shifted;
    logic [31:0] load_val;
    logic [31:0] ms_result;

    assign load_sel     = in_hold ? rbuf_q : ms.data_rdata;
    assign load_shifted = load_sel >> {exe_result[1:0], 3'b000};

    always_comb begin
        load_val = load_sel;
        if (mem_size[0]) begin
            load_val = {{24{mem_sign_exted & load_shifted[7]}}, load_shifted[7:0]};
        end else if (mem_size[1]) begin
            load_val = {{16{mem_sign_exted & load_shifted[15]}}, load_shifted[15:0]};
        end
    end

    assign ms_result = load_op ? load_val : exe_result;

    logic fwd_hit;
    logic forward_enable;
    logic dep_need_stall;

    assign fwd_hit = ms_valid_q & gr_we & (dest != 5'd0);

`ifdef MS_FWD_EN
    assign forward_enable = fwd_hit;
    assign dep_need_stall = fwd_hit & load_op & ~ms_ready_go;
`else
    assign forward_enable = 1'b0;
    assign dep_need_stall = fwd_hit;
`endif

    assign ms.ms_to_ds_forward_bus = {dep_need_stall, forward_enable, dest, ms_result};
    assign ms.ms_to_ws_valid       = ms_valid_q & ms_ready_go;
    assign ms.ms_to_ws_bus         = {bus_q[WD-1:64], ms_result, bus_q[31:0]};
    assign ms.ms_flush             = ms_valid_q & (excp | ertn | refetch);
    assign ms.ms_wr_tlbehi         = ms_valid_q & (tlbsrch | (csr_we & (csr_idx == CSR_TLBEHI)));

endmodule
